imem_loader: RTL and testbench

//  Write-side counterpart of the instruction memory. Accepts decoded instruction fields
//  (op, reg1, reg2) on a valid/ready stream and packs each set into a 9-bit word
//  {op,reg1,reg2}. Writes the words to sequential addresses in an internal writable

---
 rtl/imem_pkg.sv | 26 ++
 rtl/imem_core.sv | 35 +++
 rtl/imem_loader.sv | 123 ++++++++++++
 tb/tb_imem_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory write (loader) and fetch/decode paths.
// Contents:
//   FIELD_BITS      width of each decoded instruction field (op, reg1, reg2)
//   WORD_BITS       width of a packed instruction word
//   loader_state_t  loader session states
//   pack_ins()      packs {op, reg1, reg2} into one instruction word
package imem_pkg;

  localparam int unsigned FIELD_BITS = 3;
  localparam int unsigned WORD_BITS  = 9;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DONE
  } loader_state_t;

  function automatic logic [WORD_BITS-1:0] pack_ins(
    input logic [FIELD_BITS-1:0] op,
    input logic [FIELD_BITS-1:0] r1,
    input logic [FIELD_BITS-1:0] r2
  );
    return {op, r1, r2};
  endfunction

endpackage

// File: rtl/imem_core.sv
// Writable instruction store: 2**PC_BITS words of WORD_BITS.
// Ports:
//   clk    in   clock; writes take effect on posedge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  combinational read of mem[raddr] (old data until the write edge)
// Contents are never reset.
module imem_core
  import imem_pkg::*;
#(
  parameter int unsigned PC_BITS = 12
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [PC_BITS-1:0]   waddr,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic [PC_BITS-1:0]   raddr,
  output logic [WORD_BITS-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << PC_BITS;

  logic [WORD_BITS-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts decoded field sets on a valid/ready stream,
// packs each into a {op,reg1,reg2} word and writes it to consecutive addresses of
// an internal imem_core starting at base_addr. A combinational read port returns
// the stored fields for fetch/readback.
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   start, base_addr           begin a session (IDLE/DONE only); base sampled then
//   in_valid / in_ready        field-set handshake
//   in_op, in_reg1, in_reg2    fields -> word[8:6], word[5:3], word[2:0]
//   in_last                    marks the final word of the program
//   busy, done                 session in progress / session finished
//   overflow                   session ended at top of memory without in_last
//   count                      words written in the current/last session
//   rd_pc -> rd_op/rd_reg1/rd_reg2  combinational readback
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned PC_BITS = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PC_BITS-1:0]    base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FIELD_BITS-1:0] in_op,
  input  logic [FIELD_BITS-1:0] in_reg1,
  input  logic [FIELD_BITS-1:0] in_reg2,
  input  logic                  in_last,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [PC_BITS:0]      count,
  input  logic [PC_BITS-1:0]    rd_pc,
  output logic [FIELD_BITS-1:0] rd_op,
  output logic [FIELD_BITS-1:0] rd_reg1,
  output logic [FIELD_BITS-1:0] rd_reg2
);

  loader_state_t        r_state;
  logic [PC_BITS-1:0]   r_addr;
  logic [PC_BITS:0]     r_count;
  logic                 r_overflow;
  logic                 r_in_ready;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_hs;
  logic [WORD_BITS-1:0] w_wdata;
  logic [WORD_BITS-1:0] w_rdata;

  // r_in_ready is high exactly in LOAD, so this is the write strobe too
  assign w_hs    = in_valid & r_in_ready;
  assign w_wdata = pack_ins(in_op, in_reg1, in_reg2);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= LD_IDLE;
      r_addr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        LD_IDLE, LD_DONE: begin
          if (start) begin
            r_state    <= LD_LOAD;
            r_addr     <= base_addr;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        LD_LOAD: begin
          if (w_hs) begin
            r_count <= r_count + 1'b1;
            if (in_last || (r_addr == '1)) begin
              // top word is written but the address never wraps
              r_overflow <= ~in_last;
              r_state    <= LD_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        default: begin
          r_state    <= LD_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  imem_core #(
    .PC_BITS(PC_BITS)
  ) u_core (
    .clk   (clk),
    .we    (w_hs),
    .waddr (r_addr),
    .wdata (w_wdata),
    .raddr (rd_pc),
    .rdata (w_rdata)
  );

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign count    = r_count;
  assign rd_op    = w_rdata[8:6];
  assign rd_reg1  = w_rdata[5:3];
  assign rd_reg2  = w_rdata[2:0];

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int unsigned PCB   = 12;
  localparam int unsigned DEPTH = 4096;

  logic            clk;
  logic            reset;
  logic            start;
  logic [PCB-1:0]  base_addr;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op, in_reg1, in_reg2;
  logic            in_last;
  logic            busy, done, overflow;
  logic [PCB:0]    count;
  logic [PCB-1:0]  rd_pc;
  logic [2:0]      rd_op, rd_reg1, rd_reg2;

  imem_loader #(.PC_BITS(PCB)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_reg1(in_reg1), .in_reg2(in_reg2), .in_last(in_last),
    .busy(busy), .done(done), .overflow(overflow), .count(count),
    .rd_pc(rd_pc), .rd_op(rd_op), .rd_reg1(rd_reg1), .rd_reg2(rd_reg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a session is "loading" or "finished"; memory is a plain array.
  bit          m_loading = 0;
  bit          m_finished = 0;
  int unsigned m_addr = 0;
  int unsigned m_count = 0;
  bit          m_ovf = 0;
  logic [8:0]  m_mem [DEPTH];
  bit          m_known [DEPTH];

  // Expected outputs for the cycle currently being driven
  bit          exp_ready = 0, exp_busy = 0, exp_done = 0, exp_ovf = 0;
  int unsigned exp_count = 0;
  bit          chk_en = 0;

  // Scoreboard: completed sessions, encoded count*2+overflow
  int unsigned status_q [$];
  int unsigned sess_addrs [$];

  // Monitor: per-cycle status flags, and session results on the rising edge of done
  bit prev_done = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (in_ready !== exp_ready || busy !== exp_busy || done !== exp_done ||
          overflow !== exp_ovf || count !== exp_count[PCB:0]) begin
        errors++;
        $display("FAIL flags t=%0t: got rdy=%b busy=%b done=%b ovf=%b cnt=%0d, want rdy=%b busy=%b done=%b ovf=%b cnt=%0d",
                 $time, in_ready, busy, done, overflow, count,
                 exp_ready, exp_busy, exp_done, exp_ovf, exp_count);
      end
      if (done === 1'b1 && !prev_done) begin
        checks++;
        if (status_q.size() == 0) begin
          errors++;
          $display("FAIL session_end t=%0t: got done with cnt=%0d ovf=%b, want no session end",
                   $time, count, overflow);
        end else begin
          int unsigned s;
          s = status_q.pop_front();
          if (count !== (s / 2) || overflow !== s[0]) begin
            errors++;
            $display("FAIL session_end t=%0t: got cnt=%0d ovf=%b, want cnt=%0d ovf=%b",
                     $time, count, overflow, s / 2, s[0]);
          end
        end
      end
      prev_done = (done === 1'b1);
    end
  end

  // One clock cycle of stimulus; model advances by the same rules the loader obeys.
  task automatic cyc(input bit st, input int unsigned base, input bit v,
                     input logic [2:0] op, input logic [2:0] r1, input logic [2:0] r2,
                     input bit lst, input bit rst);
    logic [PCB-1:0] b;
    b = base[PCB-1:0];
    reset = rst; start = st; base_addr = b; in_valid = v;
    in_op = op; in_reg1 = r1; in_reg2 = r2; in_last = lst;
    exp_ready = m_loading; exp_busy = m_loading; exp_done = m_finished;
    exp_count = m_count; exp_ovf = m_ovf;
    if (rst) begin
      m_loading = 0; m_finished = 0; m_addr = 0; m_count = 0; m_ovf = 0;
    end else if (m_loading) begin
      if (v) begin
        m_mem[m_addr] = {op, r1, r2};
        m_known[m_addr] = 1;
        sess_addrs.push_back(m_addr);
        m_count++;
        if (lst || m_addr == DEPTH - 1) begin
          m_ovf = !lst;
          m_loading = 0;
          m_finished = 1;
          status_q.push_back(m_count * 2 + (m_ovf ? 1 : 0));
        end else begin
          m_addr++;
        end
      end
    end else if (st) begin
      m_loading = 1; m_finished = 0; m_addr = int'(b); m_count = 0; m_ovf = 0;
      sess_addrs.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
  endtask

  task automatic word(input logic [2:0] op, input logic [2:0] r1, input logic [2:0] r2,
                      input bit lst);
    cyc(0, 0, 1, op, r1, r2, lst, 0);
  endtask

  // Readback without advancing the clock phase seen by the stimulus; inputs are idle.
  task automatic rd_check(input int unsigned a);
    logic [PCB-1:0] p;
    p = a[PCB-1:0];
    rd_pc = p;
    #1;
    if (m_known[a]) begin
      checks++;
      if ({rd_op, rd_reg1, rd_reg2} !== m_mem[a]) begin
        errors++;
        $display("FAIL readback addr=%0d: got %h, want %h", a, {rd_op, rd_reg1, rd_reg2}, m_mem[a]);
      end
    end
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  task automatic check_session();
    int unsigned q [$];
    q = sess_addrs;
    idle();
    foreach (q[i]) rd_check(q[i]);
    realign();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; start = 0; base_addr = '0; in_valid = 0;
    in_op = '0; in_reg1 = '0; in_reg2 = '0; in_last = 0; rd_pc = '0;
    @(posedge clk); #1;
    chk_en = 1;
    cyc(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 1);
    idle(); idle();

    // Base 0, three words, valid held high
    cyc(1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
    word(3'd5, 3'd2, 3'd7, 0);
    word(3'd1, 3'd0, 3'd3, 0);
    word(3'd7, 3'd7, 3'd7, 1);
    idle();
    rd_check(0);
    checks++;
    if ({rd_op, rd_reg1, rd_reg2} !== 9'h157) begin
      errors++;
      $display("FAIL word0_pack: got %h, want 157", {rd_op, rd_reg1, rd_reg2});
    end
    rd_check(1); rd_check(2);
    realign();

    // Gapped valid: 1,0,0,1,0,1(last) from base 100 (start from DONE)
    cyc(1, 100, 0, 3'd0, 3'd0, 3'd0, 0, 0);
    word(3'd2, 3'd3, 3'd4, 0);
    idle(); idle();
    word(3'd6, 3'd1, 3'd0, 0);
    idle();
    word(3'd3, 3'd3, 3'd1, 1);
    check_session();
    rd_check(103);  // not written by this session
    realign();

    // Top of memory: 3 words without last, third is refused
    cyc(1, 4094, 0, 3'd0, 3'd0, 3'd0, 0, 0);
    word(3'd1, 3'd1, 3'd1, 0);
    word(3'd2, 3'd2, 3'd2, 0);
    word(3'd4, 3'd4, 3'd4, 0);
    check_session();
    rd_check(0);
    realign();

    // Reset after 2 of 4 words, then reload elsewhere
    cyc(1, 200, 0, 3'd0, 3'd0, 3'd0, 0, 0);
    word(3'd7, 3'd0, 3'd1, 0);
    word(3'd0, 3'd7, 3'd2, 0);
    cyc(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 1);
    idle();
    rd_check(200); rd_check(201);
    realign();
    cyc(1, 200, 0, 3'd0, 3'd0, 3'd0, 0, 0);
    word(3'd1, 3'd2, 3'd3, 0);
    word(3'd4, 3'd5, 3'd6, 1);
    check_session();

    // Start together with valid in IDLE/DONE; start during LOAD ignored
    cyc(1, 300, 1, 3'd5, 3'd5, 3'd5, 0, 0);
    word(3'd6, 3'd6, 3'd6, 0);
    cyc(1, 500, 1, 3'd2, 3'd1, 3'd0, 0, 0);
    word(3'd3, 3'd2, 3'd1, 1);
    cyc(1, 600, 1, 3'd7, 3'd1, 3'd7, 0, 0);
    idle();
    rd_check(300); rd_check(301); rd_check(302);
    realign();
    cyc(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 1);

    // Randomized sessions
    for (int s = 0; s < 14; s++) begin
      int unsigned base;
      base = ($urandom_range(0, 3) == 0) ? $urandom_range(4088, 4095) : $urandom_range(0, 4095);
      cyc(1, base, $urandom_range(0, 1), 3'($urandom_range(0, 7)), 3'd0, 3'd0, 0, 0);
      for (int c = 0; c < 30 && m_loading; c++) begin
        cyc(($urandom_range(0, 7) == 0), $urandom_range(0, 4095),
            ($urandom_range(0, 9) < 6),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0));
      end
      check_session();
      if (m_loading || $urandom_range(0, 2) == 0)
        cyc(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 1);
    end

    idle(); idle();
    chk_en = 0;
    checks++;
    if (status_q.size() != 0) begin
      errors++;
      $display("FAIL pending_sessions: got %0d unreported, want 0", status_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
